// File: rtl/dpt_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dpt_pkg : shared types and helpers for double_pulse_trigger      |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
package dpt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    WAIT2 = 2'd2,
    HOLD  = 2'd3
  } dpt_state_e;

  localparam int LED_W = 7;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/double_pulse_trigger_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | double_pulse_trigger_if : control inputs and trigger/LED outputs |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
interface double_pulse_trigger_if
  import dpt_pkg::*;
#(
  parameter int DW = 16
);

  logic             Enable;
  logic             Disc;
  logic             Clr_Counts;
  logic             Trig_Single;
  logic             Trig_Double;
  logic [LED_W-1:0] LED_Single;
  logic [LED_W-1:0] LED_Double;
  logic [DW-1:0]    Delta;
  logic             Delta_Valid;

  modport master (
    output Enable, Disc, Clr_Counts,
    input  Trig_Single, Trig_Double, LED_Single, LED_Double, Delta, Delta_Valid
  );

  modport slave (
    input  Enable, Disc, Clr_Counts,
    output Trig_Single, Trig_Double, LED_Single, LED_Double, Delta, Delta_Valid
  );

endinterface
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pulse_stretcher : start strobe -> TRIG_WIDTH-cycle pulse, reload |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module pulse_stretcher
  import dpt_pkg::*;
#(
  parameter int TRIG_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic pulse_o
);

  localparam int RW = cnt_width(TRIG_WIDTH);

  logic [RW-1:0] rem_q;
  logic          pulse_q;

  // rem_q counts the cycles still owed after the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      pulse_q <= 1'b0;
    end else if (start_i) begin
      rem_q   <= RW'(TRIG_WIDTH - 1);
      pulse_q <= 1'b1;
    end else if (rem_q != '0) begin
      rem_q   <= rem_q - 1'b1;
      pulse_q <= 1'b1;
    end else begin
      pulse_q <= 1'b0;
    end
  end

  assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/double_pulse_trigger.sv
`default_nettype none
// +------------------------------------------------------------------+
// | double_pulse_trigger : single/double pulse trigger with counters |
// | Optional DPT_SYNC_EN: two-flop synchronizer on Disc.             |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module double_pulse_trigger
  import dpt_pkg::*;
#(
  parameter int MIN_GAP    = 10,
  parameter int WINDOW     = 2500,
  parameter int TRIG_WIDTH = 4,
  parameter int HOLDOFF    = 125,
  parameter int DW         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  double_pulse_trigger_if.slave  bus_io
);

  localparam int CW = cnt_width((WINDOW > HOLDOFF) ? WINDOW : HOLDOFF);
  localparam logic [CW-1:0] c_window   = CW'(WINDOW);
  localparam logic [CW-1:0] c_holdoff  = CW'(HOLDOFF);
  localparam logic [CW-1:0] c_gap_last = CW'((MIN_GAP > 1) ? (MIN_GAP - 1) : 1);
  localparam bit            c_skip_gap = (MIN_GAP <= 1);

  logic w_disc;

`ifdef DPT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], bus_io.Disc};
    end
  end

  assign w_disc = sync_q[1];
`else
  assign w_disc = bus_io.Disc;
`endif

  dpt_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic             disc_q;
  logic [DW-1:0]    delta_q;
  logic             delta_valid_q;
  logic [LED_W-1:0] led_single_q;
  logic [LED_W-1:0] led_double_q;

  logic w_rise;
  logic w_start_single;
  logic w_start_double;
  logic w_trig_single;
  logic w_trig_double;

  assign w_rise         = w_disc & ~disc_q;
  assign w_start_single = bus_io.Enable & (state_q == IDLE)  & w_rise;
  assign w_start_double = bus_io.Enable & (state_q == WAIT2) & w_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      disc_q        <= 1'b0;
      delta_q       <= '0;
      delta_valid_q <= 1'b0;
      led_single_q  <= '0;
      led_double_q  <= '0;
    end else begin
      disc_q        <= w_disc;
      delta_valid_q <= 1'b0;

      if (!bus_io.Enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (w_rise) begin
              state_q <= c_skip_gap ? WAIT2 : GAP;
              cnt_q   <= CW'(1);
            end
          end
          GAP: begin
            if (cnt_q >= c_gap_last) begin
              state_q <= WAIT2;
            end
            cnt_q <= cnt_q + 1'b1;
          end
          WAIT2: begin
            // A rise on the last window cycle still wins over the timeout.
            if (w_rise) begin
              state_q       <= HOLD;
              cnt_q         <= CW'(1);
              delta_q       <= DW'(cnt_q);
              delta_valid_q <= 1'b1;
            end else if (cnt_q >= c_window) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HOLD: begin
            if (cnt_q >= c_holdoff) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end

      if (bus_io.Clr_Counts) begin
        led_single_q <= '0;
        led_double_q <= '0;
      end else begin
        if (w_start_single) begin
          led_single_q <= led_single_q + 1'b1;
        end
        if (w_start_double) begin
          led_double_q <= led_double_q + 1'b1;
        end
      end
    end
  end

  pulse_stretcher #(
    .TRIG_WIDTH (TRIG_WIDTH)
  ) u_single (
    .clk     (clk),
    .rst     (rst),
    .start_i (w_start_single),
    .pulse_o (w_trig_single)
  );

  pulse_stretcher #(
    .TRIG_WIDTH (TRIG_WIDTH)
  ) u_double (
    .clk     (clk),
    .rst     (rst),
    .start_i (w_start_double),
    .pulse_o (w_trig_double)
  );

  assign bus_io.Trig_Single = w_trig_single;
  assign bus_io.Trig_Double = w_trig_double;
  assign bus_io.LED_Single  = led_single_q;
  assign bus_io.LED_Double  = led_double_q;
  assign bus_io.Delta       = delta_q;
  assign bus_io.Delta_Valid = delta_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_double_pulse_trigger.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_double_pulse_trigger : directed self-checking bench           |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
module tb_double_pulse_trigger;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   t0    = 0;
  int   exp_ls = 0;
  int   exp_ld = 0;

  double_pulse_trigger_if #(.DW(16)) bus_io ();

  double_pulse_trigger #(
    .MIN_GAP    (4),
    .WINDOW     (20),
    .TRIG_WIDTH (2),
    .HOLDOFF    (8),
    .DW         (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_io)
  );

  always #5 clk = ~clk;

  // One cycle: inputs set before the edge are sampled, outputs read 1 ns after.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic advance_to(input int k);
    bus_io.Disc = 1'b0;
    while (cyc < t0 + k) tick();
  endtask

  // Disc high for exactly the cycle t0+k, so the rise is seen at t0+k.
  task automatic rise_at(input int k);
    advance_to(k);
    bus_io.Disc = 1'b1;
    tick();
    bus_io.Disc = 1'b0;
  endtask

  task automatic idle(input int n);
    bus_io.Disc = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst               = 1'b1;
    bus_io.Enable     = 1'b0;
    bus_io.Disc       = 1'b0;
    bus_io.Clr_Counts = 1'b0;
    repeat (3) tick();
    check("rst_trig_single", 32'(bus_io.Trig_Single), 32'd0);
    check("rst_trig_double", 32'(bus_io.Trig_Double), 32'd0);
    check("rst_led_single",  32'(bus_io.LED_Single),  32'd0);
    check("rst_led_double",  32'(bus_io.LED_Double),  32'd0);
    check("rst_delta",       32'(bus_io.Delta),       32'd0);
    check("rst_delta_valid", 32'(bus_io.Delta_Valid), 32'd0);
    rst           = 1'b0;
    bus_io.Enable = 1'b1;
    idle(3);

    // Isolated pulse, then a rise on the first IDLE cycle after timeout.
    t0 = cyc;
    rise_at(0);
    exp_ls = 1;
    check("iso_ts_t1",   32'(bus_io.Trig_Single), 32'd1);
    check("iso_led_s",   32'(bus_io.LED_Single),  32'(exp_ls));
    check("iso_td_t1",   32'(bus_io.Trig_Double), 32'd0);
    tick();
    check("iso_ts_t2",   32'(bus_io.Trig_Single), 32'd1);
    tick();
    check("iso_ts_t3",   32'(bus_io.Trig_Single), 32'd0);
    advance_to(20);
    check("iso_td_t20",  32'(bus_io.Trig_Double), 32'd0);
    rise_at(21);
    exp_ls = 2;
    check("t21_ts",      32'(bus_io.Trig_Single), 32'd1);
    check("t21_led_s",   32'(bus_io.LED_Single),  32'(exp_ls));
    check("t21_led_d",   32'(bus_io.LED_Double),  32'd0);
    check("t21_td",      32'(bus_io.Trig_Double), 32'd0);
    idle(30);

    // Double at +7, then rises during HOLD and after it.
    t0 = cyc;
    rise_at(0);
    exp_ls = 3;
    rise_at(7);
    exp_ld = 1;
    check("d7_td_t8",    32'(bus_io.Trig_Double), 32'd1);
    check("d7_delta",    32'(bus_io.Delta),       32'd7);
    check("d7_dv_t8",    32'(bus_io.Delta_Valid), 32'd1);
    check("d7_led_d",    32'(bus_io.LED_Double),  32'(exp_ld));
    check("d7_led_s",    32'(bus_io.LED_Single),  32'(exp_ls));
    tick();
    check("d7_td_t9",    32'(bus_io.Trig_Double), 32'd1);
    check("d7_dv_t9",    32'(bus_io.Delta_Valid), 32'd0);
    tick();
    check("d7_td_t10",   32'(bus_io.Trig_Double), 32'd0);
    rise_at(11);
    check("hold_ts",     32'(bus_io.Trig_Single), 32'd0);
    check("hold_led_s",  32'(bus_io.LED_Single),  32'(exp_ls));
    rise_at(17);
    exp_ls = 4;
    check("posthold_ts",    32'(bus_io.Trig_Single), 32'd1);
    check("posthold_led_s", 32'(bus_io.LED_Single),  32'(exp_ls));
    idle(30);

    // Second rise one cycle before MIN_GAP is ignored.
    t0 = cyc;
    rise_at(0);
    exp_ls = 5;
    rise_at(3);
    check("gap3_ts",     32'(bus_io.Trig_Single), 32'd0);
    advance_to(25);
    check("gap3_led_d",  32'(bus_io.LED_Double),  32'(exp_ld));
    check("gap3_led_s",  32'(bus_io.LED_Single),  32'(exp_ls));
    idle(10);

    // Second rise exactly at MIN_GAP.
    t0 = cyc;
    rise_at(0);
    exp_ls = 6;
    rise_at(4);
    exp_ld = 2;
    check("d4_td",       32'(bus_io.Trig_Double), 32'd1);
    check("d4_delta",    32'(bus_io.Delta),       32'd4);
    check("d4_dv",       32'(bus_io.Delta_Valid), 32'd1);
    check("d4_led_d",    32'(bus_io.LED_Double),  32'(exp_ld));
    idle(30);

    // Second rise exactly at WINDOW.
    t0 = cyc;
    rise_at(0);
    exp_ls = 7;
    rise_at(20);
    exp_ld = 3;
    check("d20_td",      32'(bus_io.Trig_Double), 32'd1);
    check("d20_delta",   32'(bus_io.Delta),       32'd20);
    check("d20_dv",      32'(bus_io.Delta_Valid), 32'd1);
    check("d20_led_d",   32'(bus_io.LED_Double),  32'(exp_ld));
    check("d20_led_s",   32'(bus_io.LED_Single),  32'(exp_ls));
    idle(30);

    // Clear keeps Delta.
    bus_io.Clr_Counts = 1'b1;
    tick();
    bus_io.Clr_Counts = 1'b0;
    check("clr_led_s",   32'(bus_io.LED_Single),  32'd0);
    check("clr_led_d",   32'(bus_io.LED_Double),  32'd0);
    check("clr_delta",   32'(bus_io.Delta),       32'd20);

    // 130 singles wrap the 7-bit count to 2.
    for (int i = 0; i < 130; i++) begin
      t0 = cyc;
      rise_at(0);
      advance_to(21);
    end
    check("wrap_led_s",  32'(bus_io.LED_Single),  32'd2);
    check("wrap_led_d",  32'(bus_io.LED_Double),  32'd0);

    // Clear coincident with an increment.
    t0 = cyc;
    bus_io.Clr_Counts = 1'b1;
    rise_at(0);
    bus_io.Clr_Counts = 1'b0;
    check("clrinc_led_s", 32'(bus_io.LED_Single),  32'd0);
    check("clrinc_ts",    32'(bus_io.Trig_Single), 32'd1);
    idle(30);

    // Reset inside an open window, coincident with a would-be double.
    t0 = cyc;
    rise_at(0);
    check("prerst_led_s", 32'(bus_io.LED_Single), 32'd1);
    advance_to(10);
    bus_io.Disc = 1'b1;
    rst         = 1'b1;
    tick();
    check("midrst_td",    32'(bus_io.Trig_Double), 32'd0);
    check("midrst_dv",    32'(bus_io.Delta_Valid), 32'd0);
    check("midrst_delta", 32'(bus_io.Delta),       32'd0);
    check("midrst_led_s", 32'(bus_io.LED_Single),  32'd0);
    check("midrst_led_d", 32'(bus_io.LED_Double),  32'd0);
    bus_io.Disc = 1'b0;
    rst         = 1'b0;
    idle(3);

    // Enable dropped mid-GAP: pulse completes, later rise is a fresh single.
    t0 = cyc;
    rise_at(0);
    check("en_ts_t1",     32'(bus_io.Trig_Single), 32'd1);
    bus_io.Enable = 1'b0;
    tick();
    check("en_ts_t2",     32'(bus_io.Trig_Single), 32'd1);
    tick();
    check("en_ts_t3",     32'(bus_io.Trig_Single), 32'd0);
    bus_io.Enable = 1'b1;
    rise_at(7);
    check("en_td_t8",     32'(bus_io.Trig_Double), 32'd0);
    check("en_ts_t8",     32'(bus_io.Trig_Single), 32'd1);
    check("en_led_s",     32'(bus_io.LED_Single),  32'd2);
    check("en_led_d",     32'(bus_io.LED_Double),  32'd0);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/double_pulse_trigger.md
Name: double_pulse_trigger

Overview:
- Producer of the single/double trigger and LED inputs consumed by the trigger-source multiplexer.
- Detects rising edges on the discriminator line and emits one single-pulse trigger per accepted first pulse.
- Emits a double-pulse trigger when a second pulse arrives inside the muon-decay window, and latches the inter-pulse delay.
- Keeps 7-bit event counts for each trigger class, which drive the LEDs.

Parameters:
- MIN_GAP, 10: minimum cycles between first and second edge (ringing rejection).
- WINDOW, 2500: maximum cycles between first and second edge (20 us at 125 MHz).
- TRIG_WIDTH, 4: width of Trig_Single and Trig_Double pulses, in cycles (>=1).
- HOLDOFF, 125: dead cycles after a double trigger.
- DW, 16: width of Delta; WINDOW < 2**DW required.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- Enable  in  1  arm detection; low forces IDLE
- Disc  in  1  discriminator output, synchronous to clk unless DPT_SYNC_EN
- Clr_Counts  in  1  synchronous clear of LED counters
- Trig_Single  out  1  single-pulse trigger
- Trig_Double  out  1  double-pulse trigger
- LED_Single  out  7  singles count mod 128
- LED_Double  out  7  doubles count mod 128
- Delta  out  DW  cycles between the edges of last double
- Delta_Valid  out  1  one-cycle strobe with a new Delta

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, edge register 0.
- Edge detect: rise at cycle t when Disc is 1 at t and 0 at t-1.
- States: IDLE, GAP, WAIT2, HOLD.
- cnt: cycles since first edge t0, so an edge at t0+k sees cnt==k.
- IDLE, rise, Enable=1:
  - go to GAP with cnt=1.
  - Start Trig_Single at t0+1 for TRIG_WIDTH cycles.
  - Increment LED_Single at t0+1.
- GAP: rises ignored; when cnt==MIN_GAP-1, go to WAIT2 next cycle.
- WAIT2, rise at cnt==k (MIN_GAP<=k<=WINDOW):
  - Trig_Double high from t0+k+1 for TRIG_WIDTH cycles.
  - Delta=k and Delta_Valid=1 at t0+k+1.
  - LED_Double increments; go to HOLD.
- WAIT2, cnt==WINDOW with no rise: return to IDLE next cycle (timeout); no double.
- Rise coincident with cnt==WINDOW: counts as double, not timeout.
- HOLD: HOLDOFF cycles, rises ignored, then IDLE. A rise on the first IDLE cycle is accepted.
- Second rise in WAIT2 does not produce Trig_Single or increment LED_Single.
- Pulse retrigger: a new Trig_Single start while the previous is active reloads width; output stays high. Trig_Double likewise.
- Enable low:
  - FSM goes to IDLE next cycle; cnt cleared.
  - Pulses in flight complete; counters hold.
- Clr_Counts: both LED counters 0 next cycle; it has priority over a simultaneous increment. Delta is unaffected.
- LED counters wrap 127 -> 0.
- cnt saturates at WINDOW; no overflow.
- rst mid-window: immediate return to reset values, including truncation of active pulses.

Optional Feature:
- DPT_SYNC_EN defined:
  - Two-flop synchronizer on Disc before edge detect.
  - Every Disc-to-output latency grows by 2 cycles; relative timing and Delta are unchanged.
- Undefined: Disc is sampled directly.

Decomposition:
- Shared package dpt_pkg:
  - state enum (IDLE, GAP, WAIT2, HOLD)
  - LED_W=7 constant
  - clog2-based counter width helper
- Sub-module pulse_stretcher (TRIG_WIDTH parameter; start in, pulse out; reload on start), instantiated twice.

Test Plan:
Bench overrides: MIN_GAP=4, WINDOW=20, TRIG_WIDTH=2, HOLDOFF=8, no sync.
- Isolated pulse, rise at t0 -> Trig_Single high t0+1..t0+2; LED_Single=1; no Trig_Double; IDLE at t0+21.
- Rise at t0 and t0+7 -> Trig_Double high t0+8..t0+9; Delta=7 with Delta_Valid at t0+8; LED_Double=1; LED_Single=1.
- Boundaries:
  - Second rise at t0+3 -> ignored, no double.
  - Second rise at t0+4 -> Delta=4.
  - Second rise at t0+20 -> Delta=20.
  - Second rise at t0+21 -> ignored; it is a new single only if after the IDLE return.
- Double, then rises 3 and 9 cycles after Trig_Double start -> first ignored (HOLD); second starts a new single; LED_Single=2.
- 130 isolated pulses -> LED_Single=2 (wrap). Clr_Counts asserted together with an increment -> 0.
- rst at t0+10 of an open window; Enable dropped mid-GAP -> all outputs 0 after rst. After Enable drop: no double from a later rise; the in-flight Trig_Single completes.
